// File: rtl/ihex_wb_writer.sv
// Packs bytes from an Intel-HEX parser into 32-bit words and writes each word
// out as a single pipelined Wishbone transaction, with sticky error capture.
module ihex_wb_writer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_byte_valid,
  input  logic [31:0] i_byte_addr,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  input  logic        i_flush,
  input  logic        i_err_clear,
  output logic        o_busy,
  output logic        o_error,
  output logic [29:0] o_err_addr,
  output logic [15:0] o_words_written,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_mosi_data,
  input  logic [31:0] i_wb_miso_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [29:0]   buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [3:0]    buf_sel_q, buf_sel_d;
  logic          buf_valid_q, buf_valid_d;
  logic          flush_pending_q, flush_pending_d;
  logic          error_q, error_d;
  logic [29:0]   err_addr_q, err_addr_d;
  logic [15:0]   words_q, words_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [1:0]    lane;
  logic          same_word;
  logic          byte_ready;
  logic          bus_done;
  logic          bus_fail;
  logic [TW-1:0] timer_inc;
  logic          in_req;

  // Write-only master: read data is never consumed.
  logic unused_miso;
  assign unused_miso = ^i_wb_miso_data;

  assign lane      = i_byte_addr[1:0];
  assign same_word = (i_byte_addr[31:2] == buf_addr_q);
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    buf_addr_d      = buf_addr_q;
    buf_data_d      = buf_data_q;
    buf_sel_d       = buf_sel_q;
    buf_valid_d     = buf_valid_q;
    flush_pending_d = flush_pending_q;
    error_d         = i_err_clear ? 1'b0 : error_q;
    err_addr_d      = err_addr_q;
    words_d         = words_q;
    timer_d         = timer_q;
    byte_ready      = 1'b0;
    bus_done        = 1'b0;
    bus_fail        = 1'b0;

    case (state_q)
      IDLE: begin
        byte_ready = !buf_valid_q ||
                     (same_word && !buf_sel_q[lane] && (buf_sel_q != 4'hF) && !flush_pending_q);
        if (i_byte_valid && byte_ready) begin
          if (!buf_valid_q) begin
            buf_addr_d = i_byte_addr[31:2];
            buf_data_d = '0;
            buf_sel_d  = '0;
          end
          buf_data_d[{lane, 3'b000} +: 8] = i_byte_data;
          buf_sel_d[lane] = 1'b1;
          buf_valid_d     = 1'b1;
        end
        // Issue decision looks at the merged buffer so a completing byte or a
        // same-cycle flush launches the write on the very next cycle.
        flush_pending_d = 1'b0;
        if (buf_valid_d && ((buf_sel_d == 4'hF) || flush_pending_q || i_flush ||
                            (i_byte_valid && !byte_ready))) begin
          state_d = REQ;
          timer_d = '0;
        end
      end

      REQ: begin
        flush_pending_d = flush_pending_q | i_flush;
        if (!i_wb_stall) begin
          if (i_wb_err) begin
            bus_fail = 1'b1;
          end else if (i_wb_ack) begin
            bus_done = 1'b1;
          end else begin
            state_d = WAIT;
            timer_d = '0;
          end
        end
      end

      WAIT: begin
        flush_pending_d = flush_pending_q | i_flush;
        if (i_wb_err) begin
          bus_fail = 1'b1;
        end else if (i_wb_ack) begin
          bus_done = 1'b1;
        end else if (timer_inc == TIMEOUT_LIMIT) begin
          bus_fail = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = IDLE;
    endcase

    if (bus_done) begin
      buf_valid_d = 1'b0;
      words_d     = words_q + 16'd1;
      state_d     = IDLE;
    end
    if (bus_fail) begin
      error_d     = 1'b1;
      err_addr_d  = buf_addr_q;
      buf_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q         <= IDLE;
      buf_addr_q      <= '0;
      buf_data_q      <= '0;
      buf_sel_q       <= '0;
      buf_valid_q     <= 1'b0;
      flush_pending_q <= 1'b0;
      error_q         <= 1'b0;
      err_addr_q      <= '0;
      words_q         <= '0;
      timer_q         <= '0;
    end else begin
      state_q         <= state_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      buf_sel_q       <= buf_sel_d;
      buf_valid_q     <= buf_valid_d;
      flush_pending_q <= flush_pending_d;
      error_q         <= error_d;
      err_addr_q      <= err_addr_d;
      words_q         <= words_d;
      timer_q         <= timer_d;
    end
  end

  // Bus outputs decode straight from the state register; the buffer cannot
  // change outside IDLE, so they stay stable through any stall.
  assign in_req    = (state_q == REQ);
  assign o_wb_cyc  = (state_q != IDLE);
  assign o_wb_stb  = in_req;
  assign o_wb_we   = in_req;
  assign o_wb_addr = in_req ? buf_addr_q : 30'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign o_wb_sel[gi]             = in_req & buf_sel_q[gi];
    assign o_wb_mosi_data[8*gi +: 8] = o_wb_sel[gi] ? buf_data_q[8*gi +: 8] : 8'h00;
  end

  assign o_byte_ready    = byte_ready & i_reset_n;
  assign o_busy          = buf_valid_q | (state_q != IDLE);
  assign o_error         = error_q;
  assign o_err_addr      = err_addr_q;
  assign o_words_written = words_q;

endmodule

// File: tb/tb_ihex_wb_writer.sv
// Directed bench: expected bus writes are queued as bytes are driven and
// popped when the writer raises stb; a scripted slave answers each request.
module tb_ihex_wb_writer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_byte_valid;
  logic [31:0] i_byte_addr;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        i_flush;
  logic        i_err_clear;
  logic        o_busy;
  logic        o_error;
  logic [29:0] o_err_addr;
  logic [15:0] o_words_written;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_mosi_data;
  logic [31:0] i_wb_miso_data;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        i_wb_stall;

  ihex_wb_writer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_byte_valid(i_byte_valid), .i_byte_addr(i_byte_addr), .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready), .i_flush(i_flush), .i_err_clear(i_err_clear),
    .o_busy(o_busy), .o_error(o_error), .o_err_addr(o_err_addr),
    .o_words_written(o_words_written),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_addr(o_wb_addr), .o_wb_mosi_data(o_wb_mosi_data), .i_wb_miso_data(i_wb_miso_data),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_stall(i_wb_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.sel = s; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] a, input logic [7:0] d, input logic fl);
    int n;
    n = 0;
    i_byte_valid = 1'b1; i_byte_addr = a; i_byte_data = d; i_flush = fl;
    #1;
    while (!o_byte_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("byte_ready_wait", {31'd0, o_byte_ready}, 32'd1);
    @(posedge clk); #1;
    i_byte_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  // resp: 0 ack one cycle later, 1 err one cycle later, 2 no response, 3 ack with acceptance
  task automatic serve(input int stall_n, input int resp);
    int n;
    wr_t e;
    logic [29:0] a0;
    logic [31:0] d0;
    n = 0;
    while (o_wb_stb !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stb_seen", {31'd0, o_wb_stb}, 32'd1);
    check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else begin e.addr = '0; e.sel = '0; e.data = '0; end
    $display("write addr=%h sel=%b data=%h", o_wb_addr, o_wb_sel, o_wb_mosi_data);
    check("wb_addr", {2'b00, o_wb_addr}, {2'b00, e.addr});
    check("wb_sel", {28'd0, o_wb_sel}, {28'd0, e.sel});
    check("wb_data", o_wb_mosi_data, e.data);
    check("wb_we_cyc", {30'd0, o_wb_we, o_wb_cyc}, 32'd3);
    check("ready_in_req", {31'd0, o_byte_ready}, 32'd0);
    a0 = o_wb_addr; d0 = o_wb_mosi_data;
    if (stall_n > 0) begin
      i_wb_stall = 1'b1;
      for (int k = 0; k < stall_n; k++) begin
        if (k == stall_n - 1) begin
          @(posedge clk); #1;
          i_wb_stall = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
        check("stall_stb", {31'd0, o_wb_stb}, 32'd1);
        check("stall_addr", {2'b00, o_wb_addr}, {2'b00, a0});
        check("stall_data", o_wb_mosi_data, d0);
      end
    end
    if (resp == 3) begin
      i_wb_ack = 1'b1;
      @(posedge clk); #1;
      i_wb_ack = 1'b0;
      check("same_cycle_ack_cyc", {31'd0, o_wb_cyc}, 32'd0);
    end else begin
      @(posedge clk); #1;
      check("wait_stb_cyc", {30'd0, o_wb_cyc, o_wb_stb}, 32'd2);
      if (resp == 2) begin
        n = 1;
        while (o_wb_cyc && n < 100) begin
          @(posedge clk); #1;
          if (o_wb_cyc) n++;
        end
        check("timeout_cycles", n, TMO);
      end else begin
        if (resp == 0) i_wb_ack = 1'b1;
        else i_wb_err = 1'b1;
        @(posedge clk); #1;
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        check("cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    i_reset_n = 1'b0; i_byte_valid = 1'b1; i_byte_addr = 32'h0; i_byte_data = 8'h0;
    i_flush = 1'b0; i_err_clear = 1'b0; i_wb_miso_data = 32'h0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, o_byte_ready}, 32'd0);
    check("rst_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    check("rst_err_words", {15'd0, o_error, o_words_written}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    i_byte_valid = 1'b0;
    i_reset_n = 1'b1;
    @(posedge clk); #1;

    // Full word, stb the cycle after the completing byte
    expect_write(30'h40, 4'hF, 32'h44332211);
    send(32'h100, 8'h11, 1'b0);
    send(32'h101, 8'h22, 1'b0);
    send(32'h102, 8'h33, 1'b0);
    send(32'h103, 8'h44, 1'b0);
    check("stb_after_full", {31'd0, o_wb_stb}, 32'd1);
    serve(0, 0);
    check("words_1", {16'd0, o_words_written}, 32'd1);
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Single byte then flush pulse
    expect_write(30'h81, 4'b0010, 32'h0000AA00);
    send(32'h205, 8'hAA, 1'b0);
    pulse_flush();
    serve(0, 0);
    check("words_2", {16'd0, o_words_written}, 32'd2);

    // Byte accepted together with flush is merged, then issued
    expect_write(30'hC0, 4'b0011, 32'h0000BBAA);
    send(32'h300, 8'hAA, 1'b0);
    send(32'h301, 8'hBB, 1'b1);
    check("stb_after_flush_byte", {31'd0, o_wb_stb}, 32'd1);
    serve(0, 0);
    check("words_3", {16'd0, o_words_written}, 32'd3);

    // Different word evicts the partial word before being accepted
    expect_write(30'h04, 4'b0001, 32'h0000005A);
    send(32'h10, 8'h5A, 1'b0);
    i_byte_valid = 1'b1; i_byte_addr = 32'h14; i_byte_data = 8'hC3;
    #1;
    check("ready_other_word", {31'd0, o_byte_ready}, 32'd0);
    serve(0, 0);
    check("ready_after_ack", {31'd0, o_byte_ready}, 32'd1);
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    check("busy_second_word", {31'd0, o_busy}, 32'd1);
    expect_write(30'h05, 4'b0001, 32'h000000C3);
    pulse_flush();
    serve(0, 0);
    check("words_5", {16'd0, o_words_written}, 32'd5);

    // Stall held three cycles
    expect_write(30'h10, 4'hF, 32'h04030201);
    send(32'h40, 8'h01, 1'b0);
    send(32'h41, 8'h02, 1'b0);
    send(32'h42, 8'h03, 1'b0);
    send(32'h43, 8'h04, 1'b0);
    serve(3, 0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (o_wb_cyc) n++;
    end
    check("single_txn", n, 0);
    check("words_6", {16'd0, o_words_written}, 32'd6);

    // Bus error, then clear
    expect_write(30'h40, 4'hF, 32'hEFBEADDE);
    send(32'h100, 8'hDE, 1'b0);
    send(32'h101, 8'hAD, 1'b0);
    send(32'h102, 8'hBE, 1'b0);
    send(32'h103, 8'hEF, 1'b0);
    serve(0, 1);
    check("err_flag", {31'd0, o_error}, 32'd1);
    check("err_addr", {2'b00, o_err_addr}, 32'h40);
    check("words_after_err", {16'd0, o_words_written}, 32'd6);
    i_err_clear = 1'b1;
    @(posedge clk); #1;
    i_err_clear = 1'b0;
    check("err_cleared", {31'd0, o_error}, 32'd0);
    check("err_addr_kept", {2'b00, o_err_addr}, 32'h40);

    // Ack in the same cycle the request is accepted
    expect_write(30'h20, 4'b0001, 32'h00000099);
    send(32'h80, 8'h99, 1'b1);
    serve(0, 3);
    check("words_7", {16'd0, o_words_written}, 32'd7);

    // No response: timeout
    expect_write(30'h23, 4'b1000, 32'h77000000);
    send(32'h8F, 8'h77, 1'b1);
    serve(0, 2);
    check("tmo_err", {31'd0, o_error}, 32'd1);
    check("tmo_err_addr", {2'b00, o_err_addr}, 32'h23);
    check("tmo_words", {16'd0, o_words_written}, 32'd7);

    // Reset while in REQ, late ack ignored
    send(32'hC0, 8'h55, 1'b1);
    i_wb_stall = 1'b1;
    n = 0;
    while (o_wb_stb !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_req_stb", {31'd0, o_wb_stb}, 32'd1);
    i_reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cyc_stb_we", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
    check("mid_rst_sel_addr", {o_wb_sel, 2'b00, o_wb_addr}, 32'd0);
    check("mid_rst_data", o_wb_mosi_data, 32'd0);
    check("mid_rst_err", {1'b0, o_error, o_err_addr}, 32'd0);
    check("mid_rst_words_busy", {15'd0, o_busy, o_words_written}, 32'd0);
    check("mid_rst_ready", {31'd0, o_byte_ready}, 32'd0);
    i_wb_ack = 1'b1; i_wb_stall = 1'b0;
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    i_wb_ack = 1'b0;
    check("late_ack_words", {16'd0, o_words_written}, 32'd0);
    check("late_ack_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ihex_wb_writer.md
IHEX_WB_WRITER -- requirements
Module: ihex_wb_writer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles waited for ack/err after a request is accepted.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_reset_n  in  1  reset, synchronous and active-low.
REQ-004 i_byte_valid  in  1  upstream parser presents a data byte.
REQ-005 i_byte_addr  in  32  byte address of the byte.
REQ-006 i_byte_data  in  8  data byte.
REQ-007 o_byte_ready  out  1  byte accepted on an edge where valid && ready.
REQ-008 i_flush  in  1  single-cycle pulse: write out any partial word (end of record or EOF).
REQ-009 i_err_clear  in  1  clears the sticky error.
REQ-010 o_busy  out  1  buffer holds data, or a bus cycle is open.
REQ-011 o_error  out  1  sticky bus error or timeout.
REQ-012 o_err_addr  out  30  word address of the last failed write.
REQ-013 o_words_written  out  16  count of acked writes, wraps 0xFFFF->0.
REQ-014 wb  wishbone master  --  pipelined Wishbone fields: cyc, stb, we, sel[3:0], addr[29:0], mosi_data[31:0], miso_data, ack, err, stall.

Function
REQ-015 Word buffer SHALL hold: buf_addr[29:0], buf_data[31:0], buf_sel[3:0], buf_valid; lane n = i_byte_addr[1:0], occupying buf_data[8n+7:8n], setting buf_sel[n] (little-endian).
REQ-016 State machine SHALL have states IDLE, REQ, WAIT.
REQ-017 In IDLE, o_byte_ready SHALL be 1 iff !buf_valid, or (i_byte_addr[31:2]==buf_addr && !buf_sel[lane]) and buf_sel != 4'hF and no flush pending.
REQ-018 An accepted byte into an empty buffer SHALL load buf_addr and clear the other lanes; into a non-empty buffer it SHALL merge its lane.
REQ-019 i_flush SHALL set flush_pending; flush_pending SHALL clear when the buffer is issued, or in IDLE with the buffer empty (flush is then a no-op).
REQ-020 IDLE->REQ when buf_valid and any of: buf_sel==4'hF, flush_pending, or i_byte_valid with a byte that fails REQ-017 (different word or duplicate lane).
REQ-021 A byte accepted at edge N that completes buf_sel==4'hF SHALL have stb=1 from the cycle after edge N.
REQ-022 Byte accepted together with i_flush SHALL be merged first; the word, including that byte, SHALL then be issued.
REQ-023 In REQ: cyc=1, stb=1, we=1, addr=buf_addr, sel=buf_sel, mosi_data=buf_data; unselected lanes SHALL drive 0.
REQ-024 REQ->WAIT on an edge with stall==0; all wb outputs SHALL hold stable while stall==1.
REQ-025 ack/err arriving in the same cycle the request is accepted SHALL be honoured (REQ->IDLE directly).
REQ-026 In WAIT: cyc=1, stb=0; a timeout counter SHALL count from 0 each cycle.
REQ-027 On ack: buf_valid<=0, o_words_written increments, state->IDLE.
REQ-028 On err, or when the counter reaches TIMEOUT_CYCLES with no ack: o_error<=1, o_err_addr<=buf_addr, buffer dropped, cyc<=0, state->IDLE.
REQ-029 ack and err in the same cycle SHALL be treated as err.
REQ-030 Only one transaction SHALL be outstanding; cyc SHALL drop for at least one cycle between transactions.
REQ-031 i_err_clear SHALL clear o_error but not o_err_addr; a new error on the same edge SHALL win.
REQ-032 o_byte_ready SHALL be 0 in REQ and WAIT.

Reset
REQ-033 While i_reset_n==0 at an edge: state IDLE, cyc=stb=we=0, sel=0, addr=0, mosi_data=0, buffer cleared, flush_pending=0, o_error=0, o_err_addr=0, o_words_written=0, o_byte_ready=0 during reset.
REQ-034 Reset mid-transaction SHALL drop cyc/stb on the next edge; any late ack SHALL be ignored.

Verification
REQ-035 Bytes 0x11,0x22,0x33,0x44 at 0x100..0x103, no stall, ack 1 cycle later -> one write: addr=0x40, sel=F, data=0x44332211; o_words_written=1.
REQ-036 Byte 0xAA at 0x205, then i_flush -> write addr=0x81, sel=0010, data=0x0000AA00.
REQ-037 Bytes at 0x10 then 0x14 -> first word (sel=0001) is written before 0x14 is accepted; o_byte_ready stays 0 until the ack.
REQ-038 stall held 3 cycles -> stb/addr/data stable for all 4 cycles; one transaction only.
REQ-039 err instead of ack at addr 0x40 -> o_error=1, o_err_addr=0x40, count unchanged; i_err_clear -> o_error=0.
REQ-040 No ack for TIMEOUT_CYCLES -> cyc drops, o_error=1; reset asserted in REQ -> cyc=0 next edge, all outputs at reset values.
